// File: rtl/apb4_pkg.sv
// Shared APB4 master types: FSM state encoding and the fixed protection attribute.
package apb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_mst_state_t;

    // Normal, secure, data access.
    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb4_intf.sv
// APB4 bus bundle with master and slave views.
interface apb4_intf #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_master.sv
// Command/response to APB4 bridge; optional ACCESS timeout via APB4_MASTER_TIMEOUT_EN.
// Latency: accept -> rsp valid in 3 cycles plus slave wait states.
// Backpressure: cmd ready only in IDLE; response held until i_rsp_ready.
module apb4_master
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    apb4_intf.master                m_apb,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_is_wr,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_cmd_wr_strb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rd_data,
    output logic                    o_rsp_err,
    output logic                    o_rsp_timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb4_master: TIMEOUT_CYCLES must be at least 1");
    end

    apb_mst_state_t state, nxt_state;

    logic                    accept;
    logic                    done;
    logic                    to_hit;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [DATA_WIDTH/8-1:0] pstrb_q;
    logic [DATA_WIDTH-1:0]   rsp_rd_data_q;
    logic                    rsp_err_q;
    logic                    psel_c;
    logic                    penable_c;
    logic                    cmd_ready_c;
    logic                    rsp_valid_c;

    assign accept = (state == ST_IDLE) && i_cmd_valid;
    assign done   = (state == ST_ACCESS) && m_apb.pready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state   = state;
        psel_c      = 1'b0;
        penable_c   = 1'b0;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (i_cmd_valid) nxt_state = ST_SETUP;
            end
            ST_SETUP: begin
                psel_c    = 1'b1;
                nxt_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                if (done || to_hit) nxt_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_c = 1'b1;
                if (i_rsp_ready) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Command is captured once at accept; the bus fields then stay frozen
    // until the next accept, which also covers the hold-last-value rule.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (accept) begin
            pwrite_q <= i_cmd_is_wr;
            paddr_q  <= i_cmd_addr;
            pwdata_q <= i_cmd_wr_data;
            pstrb_q  <= i_cmd_is_wr ? i_cmd_wr_strb : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rd_data_q <= '0;
            rsp_err_q     <= 1'b0;
        end else if (done) begin
            rsp_rd_data_q <= pwrite_q ? '0 : m_apb.prdata;
            rsp_err_q     <= m_apb.pslverr;
        end else if (to_hit) begin
            rsp_rd_data_q <= '0;
            rsp_err_q     <= 1'b1;
        end
    end

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            rsp_to_q;

    // to_cnt holds the number of completed wait cycles; pready has priority.
    assign to_hit = (state == ST_ACCESS) && !m_apb.pready &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ST_SETUP) begin
            to_cnt <= '0;
        end else if ((state == ST_ACCESS) && !m_apb.pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_to_q <= 1'b0;
        end else if (done) begin
            rsp_to_q <= 1'b0;
        end else if (to_hit) begin
            rsp_to_q <= 1'b1;
        end
    end

    assign o_rsp_timeout = rsp_to_q;
`else
    assign to_hit        = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    assign m_apb.psel    = psel_c;
    assign m_apb.penable = penable_c;
    assign m_apb.pwrite  = pwrite_q;
    assign m_apb.paddr   = paddr_q;
    assign m_apb.pwdata  = pwdata_q;
    assign m_apb.pstrb   = pstrb_q;
    assign m_apb.pprot   = PPROT_DEFAULT;

    assign o_cmd_ready   = cmd_ready_c;
    assign o_rsp_valid   = rsp_valid_c;
    assign o_rsp_rd_data = rsp_rd_data_q;
    assign o_rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb4_master.sv
// Directed self-checking bench for apb4_master; inputs change and outputs are sampled on negedge.
module tb_apb4_master;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_is_wr;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wr_data;
    logic [SW-1:0] i_cmd_wr_strb;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rd_data;
    logic          o_rsp_err;
    logic          o_rsp_timeout;

    int errors = 0;
    int checks = 0;

    apb4_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb4_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_apb        (apb),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_is_wr  (i_cmd_is_wr),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_wr_data(i_cmd_wr_data),
        .i_cmd_wr_strb(i_cmd_wr_strb),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rd_data(o_rsp_rd_data),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_timeout(o_rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // {psel, penable, pwrite, paddr[2:0], pstrb[3:0]}
    function automatic logic [9:0] bus();
        return {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pstrb};
    endfunction

    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb);
        i_cmd_valid   = 1'b1;
        i_cmd_is_wr   = wr;
        i_cmd_addr    = addr;
        i_cmd_wr_data = data;
        i_cmd_wr_strb = strb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_cmd_valid = 1'b0; i_cmd_is_wr = 1'b0; i_cmd_addr = '0;
        i_cmd_wr_data = '0; i_cmd_wr_strb = '0; i_rsp_ready = 1'b0;
        apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
        tick(); tick();
        checks++;
        if ({bus(), apb.pprot} !== 13'd0 || apb.pwdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: got bus=%b pprot=%b pwdata=%h expected all zero", bus(), apb.pprot, apb.pwdata);
        end
        checks++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_timeout} !== 3'b000 || o_rsp_rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rsp: got v/e/t=%b%b%b rd=%h expected 000 and 0", o_rsp_valid, o_rsp_err, o_rsp_timeout, o_rsp_rd_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", o_cmd_ready);
        end
    endtask

    task automatic test_write();
        issue(1'b1, 3'h5, 32'hDEADBEEF, 4'hF);
        apb.pready = 1'b1; apb.prdata = 32'h11111111;
        tick();
        i_cmd_valid = 1'b0;
        checks++;
        if (bus() !== 10'b1_0_1_101_1111 || apb.pwdata !== 32'hDEADBEEF || o_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_setup: got bus=%b pwdata=%h rdy=%b expected 1010111111 deadbeef 0", bus(), apb.pwdata, o_cmd_ready);
        end
        tick();
        checks++;
        if (bus() !== 10'b1_1_1_101_1111 || o_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_access: got bus=%b rsp_valid=%b expected 1110111111 0", bus(), o_rsp_valid);
        end
        tick();
        checks++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_timeout, apb.psel, apb.penable} !== 5'b10000 || o_rsp_rd_data !== 32'd0) begin
            errors++;
            $display("FAIL wr_resp: got v/e/t/sel/en=%b%b%b%b%b rd=%h expected 10000 0",
                     o_rsp_valid, o_rsp_err, o_rsp_timeout, apb.psel, apb.penable, o_rsp_rd_data);
        end
        i_rsp_ready = 1'b1; apb.pready = 1'b0;
        tick();
        i_rsp_ready = 1'b0;
        checks++;
        if ({o_cmd_ready, o_rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL wr_idle: got rdy/valid=%b%b expected 10", o_cmd_ready, o_rsp_valid);
        end
    endtask

    task automatic test_read_wait();
        issue(1'b0, 3'h2, 32'hA5A5A5A5, 4'hF);
        apb.pready = 1'b0; apb.prdata = 32'hFFFFFFFF;
        tick();
        i_cmd_valid = 1'b0;
        checks++;
        if (bus() !== 10'b1_0_0_010_0000) begin
            errors++;
            $display("FAIL rd_setup: got %b expected 1000100000", bus());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus() !== 10'b1_1_0_010_0000 || o_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rd_access%0d: got bus=%b valid=%b expected 1100100000 0", i, bus(), o_rsp_valid);
            end
            if (i == 2) begin
                apb.pready = 1'b1; apb.prdata = 32'h12345678;
            end
        end
        tick();
        apb.pready = 1'b0; apb.prdata = 32'h0;
        checks++;
        if ({o_rsp_valid, o_rsp_err, apb.psel} !== 3'b100 || o_rsp_rd_data !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_resp: got v/e/sel=%b%b%b rd=%h expected 100 12345678", o_rsp_valid, o_rsp_err, apb.psel, o_rsp_rd_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_slverr();
        issue(1'b0, 3'h7, 32'h0, 4'h0);
        apb.pready = 1'b1; apb.pslverr = 1'b1; apb.prdata = 32'hCAFEF00D;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        tick();
        apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = 32'h0BADBAD0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({o_rsp_valid, o_rsp_err, o_cmd_ready} !== 3'b110 || o_rsp_rd_data !== 32'hCAFEF00D) begin
                errors++;
                $display("FAIL err_hold%0d: got v/e/rdy=%b%b%b rd=%h expected 110 cafef00d", i, o_rsp_valid, o_rsp_err, o_cmd_ready, o_rsp_rd_data);
            end
            tick();
        end
        checks++;
        if ({o_rsp_valid, o_rsp_err} !== 2'b11) begin
            errors++;
            $display("FAIL err_hold_end: got %b%b expected 11", o_rsp_valid, o_rsp_err);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        checks++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL err_release: got valid/rdy=%b%b expected 01", o_rsp_valid, o_cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 3'h1, 32'h00000111, 4'h3);
        apb.pready = 1'b1; i_rsp_ready = 1'b1;
        tick();
        // payload changes while valid stays high: it must not disturb the busy transfer
        issue(1'b1, 3'h6, 32'h00000666, 4'hC);
        tick();
        checks++;
        if (bus() !== 10'b1_1_1_001_0011 || apb.pwdata !== 32'h00000111 || o_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_access1: got bus=%b pwdata=%h rdy=%b expected 1110010011 111 0", bus(), apb.pwdata, o_cmd_ready);
        end
        tick();
        checks++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_resp1: got valid/rdy=%b%b expected 10", o_rsp_valid, o_cmd_ready);
        end
        tick();
        checks++;
        if ({o_cmd_ready, apb.psel, o_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_idle_gap: got rdy/sel/valid=%b%b%b expected 100", o_cmd_ready, apb.psel, o_rsp_valid);
        end
        tick();
        i_cmd_valid = 1'b0;
        checks++;
        if (bus() !== 10'b1_0_1_110_1100 || apb.pwdata !== 32'h00000666) begin
            errors++;
            $display("FAIL b2b_setup2: got bus=%b pwdata=%h expected 1011101100 666", bus(), apb.pwdata);
        end
        tick(); tick(); tick();
        apb.pready = 1'b0; i_rsp_ready = 1'b0;
        checks++;
        if ({o_cmd_ready, o_rsp_valid, apb.psel} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_done: got rdy/valid/sel=%b%b%b expected 100", o_cmd_ready, o_rsp_valid, apb.psel);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'h4, 32'h0, 4'h0);
        apb.pready = 1'b0; apb.prdata = 32'h77777777;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({apb.psel, apb.penable, o_rsp_valid, o_cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid: got sel/en/valid/rdy=%b%b%b%b expected 0001", apb.psel, apb.penable, o_rsp_valid, o_cmd_ready);
        end
        rst_n = 1'b1; apb.pready = 1'b1; i_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({o_rsp_valid, apb.psel, o_cmd_ready} !== 3'b001 || o_rsp_rd_data !== 32'd0) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: got valid/sel/rdy=%b%b%b rd=%h expected 001 0", i, o_rsp_valid, apb.psel, o_cmd_ready, o_rsp_rd_data);
            end
        end
        apb.pready = 1'b0; i_rsp_ready = 1'b0;
    endtask

`ifdef APB4_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        issue(1'b0, 3'h3, 32'h0, 4'h0);
        apb.pready = 1'b0; apb.prdata = 32'h99999999;
        tick();
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({apb.penable, o_rsp_valid} !== 2'b10) begin
                errors++;
                $display("FAIL to_access%0d: got en/valid=%b%b expected 10", i, apb.penable, o_rsp_valid);
            end
        end
        tick();
        checks++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_timeout, apb.psel} !== 4'b1110 || o_rsp_rd_data !== 32'd0) begin
            errors++;
            $display("FAIL to_resp: got v/e/t/sel=%b%b%b%b rd=%h expected 1110 0", o_rsp_valid, o_rsp_err, o_rsp_timeout, apb.psel, o_rsp_rd_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        issue(1'b0, 3'h3, 32'h0, 4'h0);
        tick();
        i_cmd_valid = 1'b0;
        tick(); tick(); tick(); tick();
        apb.pready = 1'b1;
        tick();
        apb.pready = 1'b0;
        checks++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_timeout} !== 3'b100 || o_rsp_rd_data !== 32'h99999999) begin
            errors++;
            $display("FAIL to_pready_wins: got v/e/t=%b%b%b rd=%h expected 100 99999999", o_rsp_valid, o_rsp_err, o_rsp_timeout, o_rsp_rd_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        issue(1'b0, 3'h3, 32'h0, 4'h0);
        apb.pready = 1'b0; apb.prdata = 32'h0000ABCD;
        tick();
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if ({apb.psel, apb.penable, o_rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL nto_still_access: got sel/en/valid=%b%b%b expected 110", apb.psel, apb.penable, o_rsp_valid);
        end
        apb.pready = 1'b1;
        tick();
        apb.pready = 1'b0;
        checks++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_timeout} !== 3'b100 || o_rsp_rd_data !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL nto_resp: got v/e/t=%b%b%b rd=%h expected 100 0000abcd", o_rsp_valid, o_rsp_err, o_rsp_timeout, o_rsp_rd_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
`ifdef APB4_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
